// File: rtl/fetch_stage.sv
// fetch_stage: IF stage between the PC register and the IF/ID register.
// Optional FETCH_ALIGN_CHECK_EN: misaligned PCs skip memory, flag fetch_misaligned.
`timescale 1ns/1ps
module fetch_stage #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] if_id_instr,
  output logic [ADDR_WIDTH-1:0] if_id_pc4,
  output logic                  if_id_valid,
  output logic                  fetch_busy
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic                  fetch_misaligned
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_e;

  state_e state_q, state_d;
  logic req_q, req_d;
  logic drop_q, drop_d;
  logic valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] pc4_q, pc4_d;
  logic [ADDR_WIDTH-1:0] hpc4_q, hpc4_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] hins_q, hins_d;
  logic issue, load;
  logic [ADDR_WIDTH-1:0] addr_p4;
`ifdef FETCH_ALIGN_CHECK_EN
  logic mis_q, mis_d;
  logic pend_q, pend_d;
`endif

  assign addr_p4 = addr_q + ADDR_WIDTH'(4);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    drop_d  = drop_q;
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    hins_d  = hins_q;
    hpc4_d  = hpc4_q;
    fetch_busy = 1'b0;
    issue = 1'b0;
    load  = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    mis_d  = mis_q;
    pend_d = pend_q;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef FETCH_ALIGN_CHECK_EN
        if (pend_q) begin
          fetch_busy = !flush;
          if (flush || drop_q) begin
            drop_d = 1'b0;
            pend_d = 1'b0;
          end else if (!stall) begin
            pend_d  = 1'b0;
            pc4_d   = addr_p4;
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            mis_d   = 1'b1;
          end
        end else
`endif
        begin
          // pc_in is still pre-redirect during a flush
          issue  = 1'b1;
          drop_d = flush;
        end
      end
      WAIT: begin
        if (flush) begin
          if (imem_ready) begin
            req_d   = 1'b0;
            drop_d  = 1'b0;
            state_d = IDLE;
          end else begin
            drop_d = 1'b1;
          end
        end else if (!imem_ready) begin
          fetch_busy = 1'b1;
        end else if (drop_q) begin
          drop_d = 1'b0;
          issue  = 1'b1;
        end else if (stall) begin
          hins_d  = imem_rdata;
          hpc4_d  = addr_p4;
          req_d   = 1'b0;
          state_d = HOLD;
          fetch_busy = 1'b1;
        end else begin
          instr_d = imem_rdata;
          pc4_d   = addr_p4;
          load    = 1'b1;
          issue   = 1'b1;
        end
      end
      HOLD: begin
        if (flush) begin
          state_d = IDLE;
        end else if (stall) begin
          fetch_busy = 1'b1;
        end else begin
          instr_d = hins_q;
          pc4_d   = hpc4_q;
          load    = 1'b1;
          issue   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) valid_d = 1'b1;
    if (flush) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end
`ifdef FETCH_ALIGN_CHECK_EN
    if (load || flush) mis_d = 1'b0;
`endif
    if (issue) begin
      addr_d  = pc_in;
      req_d   = 1'b1;
      state_d = WAIT;
`ifdef FETCH_ALIGN_CHECK_EN
      if (pc_in[1:0] != 2'b00) begin
        req_d   = 1'b0;
        pend_d  = 1'b1;
        state_d = IDLE;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      drop_q  <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      hins_q  <= '0;
      hpc4_q  <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      mis_q   <= 1'b0;
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      hins_q  <= hins_d;
      hpc4_q  <= hpc4_d;
`ifdef FETCH_ALIGN_CHECK_EN
      mis_q   <= mis_d;
      pend_q  <= pend_d;
`endif
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign fetch_misaligned = mis_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: random stall/flush/latency against an in-order fetch-stream model.
`timescale 1ns/1ps
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;
  logic [31:0] pc_in;
  logic stall, flush;
  logic imem_req;
  logic [31:0] imem_addr;
  logic imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic if_id_valid;
  logic fetch_busy;

  fetch_stage #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .NOP_INSTR(NOP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pc_in(pc_in),
    .stall(stall),
    .flush(flush),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .if_id_instr(if_id_instr),
    .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid),
    .fetch_busy(fetch_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] pc_m, exp_addr, tgt, tgt_f;
  logic [31:0] addr_p, instr_p, pc4_p;
  logic req_p, rdy_p, flush_p, stall_p, busy_p, v_p;
  int wait_cnt, lat, fix_lat, stall_pct, flush_pct, idle_cnt, loads;
  bit use_force, f_flush, f_stall, busy_never, saw_wrap;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic reset_model(input logic [31:0] start);
    pc_m = start;
    exp_addr = start;
    req_p = 1'b0;
    rdy_p = 1'b0;
    flush_p = 1'b0;
    stall_p = 1'b0;
    busy_p = 1'b0;
    v_p = 1'b0;
    pc4_p = '0;
    instr_p = NOP;
    addr_p = '0;
    idle_cnt = 0;
  endtask

  // One cycle: drive at negedge, check pre-edge, advance PC, check post-edge.
  task automatic step();
    if (use_force) begin
      flush = f_flush;
      stall = f_stall;
      tgt = tgt_f;
    end else begin
      flush = ($urandom_range(99) < 32'(flush_pct));
      stall = ($urandom_range(99) < 32'(stall_pct));
      tgt = $urandom & 32'hFFFF_FFFC;
    end
    if (imem_req && (!req_p || rdy_p)) begin
      wait_cnt = 1;
      lat = (fix_lat > 0) ? fix_lat : int'($urandom_range(4, 1));
    end else if (imem_req) begin
      wait_cnt++;
    end
    imem_ready = imem_req && (wait_cnt >= lat);
    imem_rdata = imem_ready ? mem_f(imem_addr) : $urandom;
    pc_in = pc_m;
    #1;
    if (flush) chk("busy_on_flush", 32'(fetch_busy), 32'd0);
    else if (imem_req && !imem_ready)
      chk("busy_waiting", 32'(fetch_busy), 32'd1);
    if (busy_never) chk("busy_1cyc_mem", 32'(fetch_busy), 32'd0);
    req_p = imem_req;
    rdy_p = imem_ready;
    addr_p = imem_addr;
    flush_p = flush;
    stall_p = stall;
    busy_p = fetch_busy;
    v_p = if_id_valid;
    instr_p = if_id_instr;
    pc4_p = if_id_pc4;
    @(posedge clk);
    if (flush_p) begin
      pc_m = tgt;
      exp_addr = tgt;
    end else if (!busy_p) begin
      pc_m = pc_m + 32'd4;
    end
    @(negedge clk);
    if (flush_p) begin
      chk("flush_valid", 32'(if_id_valid), 32'd0);
      chk("flush_nop", if_id_instr, NOP);
    end else if (stall_p) begin
      chk("stall_valid", 32'(if_id_valid), 32'(v_p));
      chk("stall_instr", if_id_instr, instr_p);
      chk("stall_pc4", if_id_pc4, pc4_p);
    end
    if (req_p && !rdy_p) begin
      chk("req_stable", 32'(imem_req), 32'd1);
      chk("addr_stable", imem_addr, addr_p);
    end
    if (!flush_p && if_id_valid && (!v_p || if_id_pc4 != pc4_p)) begin
      chk("load_pc4", if_id_pc4, exp_addr + 32'd4);
      chk("load_instr", if_id_instr, mem_f(exp_addr));
      if (exp_addr == 32'hFFFF_FFFC && if_id_pc4 == 32'd0) saw_wrap = 1'b1;
      exp_addr = exp_addr + 32'd4;
      loads++;
      idle_cnt = 0;
    end else if (flush_p) begin
      idle_cnt = 0;
    end else begin
      idle_cnt++;
    end
    if (idle_cnt > 60) begin
      chk("progress_timeout", 32'(idle_cnt), 32'd0);
      idle_cnt = 0;
    end
  endtask

  initial begin
    reset = 1'b1;
    pc_in = '0;
    stall = 1'b0;
    flush = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = '0;
    wait_cnt = 0;
    lat = 1;
    fix_lat = 1;
    stall_pct = 0;
    flush_pct = 0;
    loads = 0;
    use_force = 1'b1;
    f_flush = 1'b0;
    f_stall = 1'b0;
    tgt_f = '0;
    busy_never = 1'b0;
    saw_wrap = 1'b0;
    reset_model('0);
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", 32'(if_id_valid), 32'd0);
    chk("rst_instr", if_id_instr, NOP);
    chk("rst_pc4", if_id_pc4, 32'd0);
    chk("rst_busy", 32'(fetch_busy), 32'd0);
    reset = 1'b0;
    reset_model('0);

    // back-to-back with single-cycle memory
    busy_never = 1'b1;
    repeat (8) step();
    busy_never = 1'b0;
    chk("b2b_loads", 32'(loads), 32'd7);

    // redirect to 0x100 with three-cycle memory
    fix_lat = 3;
    f_flush = 1'b1;
    tgt_f = 32'h100;
    step();
    f_flush = 1'b0;
    repeat (12) step();

    // data returns under stall
    fix_lat = 1;
    f_stall = 1'b1;
    repeat (5) step();
    f_stall = 1'b0;
    repeat (4) step();

    // flush mid-wait, redirect to 0x200
    fix_lat = 3;
    step();
    f_flush = 1'b1;
    tgt_f = 32'h200;
    step();
    f_flush = 1'b0;
    repeat (10) step();

    // flush and stall together while parked
    fix_lat = 1;
    f_stall = 1'b1;
    repeat (4) step();
    f_flush = 1'b1;
    tgt_f = 32'h400;
    step();
    chk("hold_flush_idle", 32'(imem_req), 32'd0);
    f_flush = 1'b0;
    f_stall = 1'b0;
    repeat (6) step();

    // randomized traffic
    use_force = 1'b0;
    fix_lat = 0;
    stall_pct = 25;
    flush_pct = 6;
    repeat (1500) step();
    chk("random_progress", 32'(loads > 200), 32'd1);

    // reset while a request is outstanding
    use_force = 1'b1;
    f_flush = 1'b1;
    f_stall = 1'b0;
    tgt_f = 32'h300;
    fix_lat = 4;
    step();
    f_flush = 1'b0;
    repeat (2) step();
    chk("pre_rst_req", 32'(imem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_valid", 32'(if_id_valid), 32'd0);
    chk("midrst_instr", if_id_instr, NOP);
    chk("midrst_pc4", if_id_pc4, 32'd0);
    chk("midrst_busy", 32'(fetch_busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    reset_model(32'hFFFF_FFF0);

    // pc4 wraps past the top of the address space
    fix_lat = 1;
    repeat (10) step();
    chk("pc4_wrap_seen", 32'(saw_wrap), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage directly downstream of the PC register (nextPC). Each issued fetch latches the PC, runs a req/ready handshake with instruction memory of variable latency, and loads the IF/ID pipeline register with instruction and PC+4. It drives fetch_busy back to the PC register's stall input so the PC holds while a fetch is outstanding or parked. Honours hazard stall and branch/jump flush.

Parameters:
ADDR_WIDTH, 32, width of PC and imem address
DATA_WIDTH, 32, instruction width
NOP_INSTR, 32'h00000000, value driven on if_id_instr when no valid instruction is held

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
pc_in  in  ADDR_WIDTH  nextPC from the PC register
stall  in  1  hazard unit: ID stage cannot accept; IF/ID must hold
flush  in  1  branch/jump taken; squash IF/ID and any in-flight fetch
imem_req  out  1  fetch request to instruction memory
imem_addr  out  ADDR_WIDTH  fetch address, stable while imem_req=1
imem_ready  in  1  memory returns imem_rdata this cycle
imem_rdata  in  DATA_WIDTH  fetched instruction
if_id_instr  out  DATA_WIDTH  IF/ID instruction
if_id_pc4  out  ADDR_WIDTH  IF/ID fetch address + 4
if_id_valid  out  1  IF/ID holds a real instruction
fetch_busy  out  1  hold request to the PC register

Behaviour:
- Reset (async, active-high): state=IDLE, imem_req=0, imem_addr=0, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc4=0, drop flag=0, hold buffer cleared. fetch_busy=0. Reset mid-request abandons it; memory must tolerate req falling without ready.
- States: IDLE, WAIT, HOLD.
- IDLE: on edge, imem_addr<=pc_in, imem_req<=1, go WAIT. fetch_busy=0 (PC advances same edge).
- WAIT, imem_ready=0: hold req/addr; fetch_busy=1 unless flush.
- WAIT, imem_ready=1, drop=0, flush=0, stall=0: IF/ID<= {imem_rdata, imem_addr+4, valid=1}; same edge issue next fetch: imem_addr<=pc_in, stay WAIT (back-to-back, one instruction/cycle with 1-cycle memory). fetch_busy=0.
- WAIT, imem_ready=1, stall=1, flush=0, drop=0: capture data+pc4 into hold buffer, imem_req<=0, go HOLD; IF/ID unchanged; fetch_busy=1.
- WAIT, imem_ready=1, drop=1: discard data, clear drop, issue pc_in, stay WAIT; IF/ID not loaded (valid stays 0 from flush).
- HOLD: fetch_busy=1 while stall=1. When stall=0: IF/ID<=hold buffer, valid=1, issue pc_in, go WAIT, fetch_busy=0.
- flush=1 (any state, priority over stall and ready): fetch_busy=0 that cycle so PC register takes the redirect; if_id_valid<=0, if_id_instr<=NOP_INSTR. WAIT with ready=0: set drop, stay WAIT. WAIT with ready=1: discard data, go IDLE. HOLD: discard buffer, go IDLE. IDLE: stay IDLE semantics (issue pc_in normally; pc_in is pre-redirect, so also set drop). Net: first instruction loaded after flush is the one at the redirect target.
- stall=1 with no arriving data: IF/ID holds all fields; outstanding request continues.
- pc4 arithmetic: ADDR_WIDTH bits, wraps modulo 2^ADDR_WIDTH (0xFFFFFFFC -> 0x00000000).
- imem_addr/imem_req only change on issue, completion or reset; never while req=1 and ready=0.

Optional Feature:
FETCH_ALIGN_CHECK_EN: when defined, adds output fetch_misaligned (1 bit, reset 0). On issue with pc_in[1:0]!=0, no memory request is made; next edge IF/ID<= {NOP_INSTR, pc_in+4, valid=0} and fetch_misaligned<=1 for that entry (cleared on next IF/ID load or flush); state returns IDLE. Without the macro: no port, address bits [1:0] passed to memory unchanged.

Test Plan:
- Reset then 1-cycle memory, pc 0,4,8 -> if_id_instr follows rdata each cycle, if_id_pc4 = 4,8,12, fetch_busy=0 throughout.
- 3-cycle memory latency at pc 0x100 -> imem_addr stable 0x100 for 3 cycles, fetch_busy=1 for 2 cycles, then if_id_pc4=0x104 valid=1.
- Data returns with stall=1 for 4 cycles -> IF/ID unchanged, HOLD entered; on stall fall IF/ID = captured instr, next req issued at held pc_in.
- flush while WAIT with latency 3, redirect target 0x200 -> stale data discarded, if_id_valid=0, next valid entry has pc4=0x204.
- flush and stall asserted same cycle in HOLD -> buffer discarded, valid=0, IDLE, fetch_busy=0.
- Assert reset mid-WAIT -> imem_req=0, if_id_valid=0, if_id_instr=NOP_INSTR immediately; pc4 wrap check at 0xFFFFFFFC -> 0x00000000.
